// File: rtl/bcd_count_pkg.sv
// Shared types and constants for the BCD run-control sequencer.
package bcd_count_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX        = 4'd9;
    localparam int         DIGITS_DEFAULT = 4;

    // True when a 4-bit nibble holds a legal decimal digit.
    function automatic logic bcd_digit_valid(input logic [3:0] d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade counter stage: clears synchronously, increments on inc,
// wraps 9 -> 0 and raises carry so the next stage can step.
module bcd_digit
    import bcd_count_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] digit,
    output logic       carry
);

    logic [3:0] r_digit;

    // Digit register: clear wins over increment, 9 wraps to 0.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples pre-edge values regardless of statement order.
        if (reset || clr) begin
            r_digit <= 4'd0;
        end else if (inc) begin
            r_digit <= (r_digit == BCD_MAX) ? 4'd0 : r_digit + 4'd1;
        end
    end

    assign digit = r_digit;
    assign carry = inc & (r_digit == BCD_MAX);

endmodule

// File: rtl/bcd_count_ctrl.sv
// Run-control sequencer for a chain of BCD decade counters.
// Optional feature: define BCD_COUNT_CTRL_AUTORELOAD_EN to reload the count
// to zero on the terminal tick and keep running instead of halting in DONE.
module bcd_count_ctrl
    import bcd_count_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                clear,
    input  logic                tick,
    input  logic [4*DIGITS-1:0] limit,
    output logic [4*DIGITS-1:0] count,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int W = 4 * DIGITS;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_limit;
    logic           r_done;
    logic           r_err;

    logic [W-1:0]   w_count;
    logic [DIGITS:0] w_carry;
    logic           w_limit_ok;
    logic           w_at_limit;
    logic           w_inc;
    logic           w_clr;
    logic           w_latch;
    logic           w_done_nxt;
    logic           w_err_nxt;
    logic           w_unused_carry;

    // Check every nibble of the incoming limit for a legal decimal digit.
    always_comb begin
        // NOTE: every combinational output gets a default first so no
        // path leaves it unassigned and no latch is inferred.
        w_limit_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!bcd_digit_valid(limit[4*i +: 4])) begin
                w_limit_ok = 1'b0;
            end
        end
    end

    assign w_at_limit = (w_count == r_limit);

    // Next state and datapath controls; clear > start > stop > tick.
    always_comb begin
        w_state_nxt = r_state;
        w_inc       = 1'b0;
        w_clr       = 1'b0;
        w_latch     = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        if (clear) begin
            w_state_nxt = ST_IDLE;
            w_clr       = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        if (w_limit_ok) begin
                            w_state_nxt = ST_RUN;
                            w_clr       = 1'b1;
                            w_latch     = 1'b1;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        w_state_nxt = ST_PAUSE;
                    end else if (tick) begin
                        if (w_at_limit) begin
                            w_done_nxt = 1'b1;
`ifdef BCD_COUNT_CTRL_AUTORELOAD_EN
                            w_clr = 1'b1;
`else
                            w_state_nxt = ST_DONE;
`endif
                        end else begin
                            w_inc = 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (start) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State register, limit latch and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_limit <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) begin
                r_limit <= limit;
            end
            r_done <= w_done_nxt;
            r_err  <= w_err_nxt;
        end
    end

    // Ripple-enabled decade chain: each stage steps when all lower are 9.
    assign w_carry[0] = w_inc;

    genvar g;
    for (g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk   (clk),
            .reset (reset),
            .clr   (w_clr),
            .inc   (w_carry[g]),
            .digit (w_count[4*g +: 4]),
            .carry (w_carry[g+1])
        );
    end

    // The count never passes the limit, so the top carry is never consumed.
    assign w_unused_carry = w_carry[DIGITS];

    assign count = w_count;
    assign busy  = (r_state == ST_RUN) || (r_state == ST_PAUSE);
    assign done  = r_done;
    assign err   = r_err;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Scoreboard bench for bcd_count_ctrl (DIGITS = 4). Expectations follow the
// build: BCD_COUNT_CTRL_AUTORELOAD_EN selects reload vs halt at terminal.
module tb_bcd_count_ctrl;

`ifdef BCD_COUNT_CTRL_AUTORELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic        stop;
    logic        clear;
    logic        tick;
    logic [15:0] limit;
    logic [15:0] count;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct {
        string       name;
        logic [15:0] count;
        logic        busy;
        logic        done;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    exp_t m_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    bcd_count_ctrl #(.DIGITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .stop  (stop),
        .clear (clear),
        .tick  (tick),
        .limit (limit),
        .count (count),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'((v)        % 10);
        r[7:4]   = 4'((v / 10)   % 10);
        r[11:8]  = 4'((v / 100)  % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Drive one cycle of inputs and queue the response expected after the edge.
    task automatic step(input string name, input logic rs, input logic st, input logic sp,
                        input logic cl, input logic tk, input logic [15:0] lim,
                        input logic [15:0] ec, input logic eb, input logic ed, input logic ee);
        exp_t e;
        @(negedge clk);
        reset = rs; start = st; stop = sp; clear = cl; tick = tk; limit = lim;
        @(posedge clk);
        e.name = name; e.count = ec; e.busy = eb; e.done = ed; e.err = ee;
        sb_q.push_back(e);
    endtask

    // Monitor: outputs settle just after each edge; compare against the queue.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                m_e = sb_q.pop_front();
                check({m_e.name, ".count"}, count, m_e.count);
                check({m_e.name, ".busy"}, {15'd0, busy}, {15'd0, m_e.busy});
                check({m_e.name, ".done"}, {15'd0, done}, {15'd0, m_e.done});
                check({m_e.name, ".err"},  {15'd0, err},  {15'd0, m_e.err});
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; tick = 1'b0; limit = '0;

        // Reset state
        step("rst0", 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
        step("rst1", 1, 1, 0, 0, 1, 16'h0012, 16'h0000, 0, 0, 0);

        // Limit 12: start (same-cycle tick ignored), 12 increments, terminal
        step("start12", 0, 1, 0, 0, 1, 16'h0012, 16'h0000, 1, 0, 0);
        for (int k = 1; k <= 12; k++)
            step("cnt12", 0, 0, 0, 0, 1, 16'h0000, to_bcd(k), 1, 0, 0);
        step("term12", 0, 0, 0, 0, 1, 16'h0000, AR ? 16'h0000 : 16'h0012, AR, 1, 0);
        step("post12", 0, 0, 0, 0, 1, 16'h0000, AR ? 16'h0001 : 16'h0012, AR, 0, 0);
        step("clr_a", 0, 0, 0, 1, 1, 16'h0000, 16'h0000, 0, 0, 0);

        // Invalid limit rejected, valid one accepted
        step("bad_lim", 0, 1, 0, 0, 0, 16'h00A5, 16'h0000, 0, 0, 1);
        step("bad_idle", 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0);
        step("ok_lim5", 0, 1, 0, 0, 0, 16'h0005, 16'h0000, 1, 0, 0);
        step("clr_b", 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0);

        // Limit 100: pause/resume, start ignored in RUN, two-digit carry
        step("start100", 0, 1, 0, 0, 0, 16'h0100, 16'h0000, 1, 0, 0);
        for (int k = 1; k <= 7; k++)
            step("cnt100", 0, 0, 0, 0, 1, 16'h0000, to_bcd(k), 1, 0, 0);
        step("stop_tick", 0, 0, 1, 0, 1, 16'h0000, 16'h0007, 1, 0, 0);
        step("pause_tick", 0, 0, 0, 0, 1, 16'h0000, 16'h0007, 1, 0, 0);
        step("resume", 0, 1, 0, 0, 0, 16'h0003, 16'h0007, 1, 0, 0);
        step("run_start", 0, 1, 0, 0, 1, 16'h0003, 16'h0008, 1, 0, 0);
        for (int k = 9; k <= 99; k++)
            step("cnt100", 0, 0, 0, 0, 1, 16'h0000, to_bcd(k), 1, 0, 0);
        step("carry100", 0, 0, 0, 0, 1, 16'h0000, 16'h0100, 1, 0, 0);
        step("term100", 0, 0, 0, 0, 1, 16'h0000, AR ? 16'h0000 : 16'h0100, AR, 1, 0);
        step("clr_c", 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0);

        // Clear together with a terminal tick suppresses done
        step("start2", 0, 1, 0, 0, 0, 16'h0002, 16'h0000, 1, 0, 0);
        step("cnt2", 0, 0, 0, 0, 1, 16'h0000, 16'h0001, 1, 0, 0);
        step("cnt2", 0, 0, 0, 0, 1, 16'h0000, 16'h0002, 1, 0, 0);
        step("clr_term", 0, 0, 0, 1, 1, 16'h0000, 16'h0000, 0, 0, 0);
        step("no_done", 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0);

        // Reset mid-run wins over start and tick
        step("start5", 0, 1, 0, 0, 0, 16'h0005, 16'h0000, 1, 0, 0);
        step("cnt5", 0, 0, 0, 0, 1, 16'h0000, 16'h0001, 1, 0, 0);
        step("rst_run", 1, 1, 0, 0, 1, 16'h0005, 16'h0000, 0, 0, 0);
        step("rst_idle", 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0);

        // Limit 0: first tick is terminal
        step("start0", 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0);
        step("term0", 0, 0, 0, 0, 1, 16'h0000, 16'h0000, AR, 1, 0);
        step("clr_d", 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0);

        // Limit all 9s: full carry ripple, terminal at 9999, no overflow
        step("start9999", 0, 1, 0, 0, 0, 16'h9999, 16'h0000, 1, 0, 0);
        for (int k = 1; k <= 9999; k++)
            step("cnt9999", 0, 0, 0, 0, 1, 16'h0000, to_bcd(k), 1, 0, 0);
        step("term9999", 0, 0, 0, 0, 1, 16'h0000, AR ? 16'h0000 : 16'h9999, AR, 1, 0);
        step("clr_e", 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0);

        // Limit 3 with sustained tick: periodic reload or halt
        step("start3", 0, 1, 0, 0, 0, 16'h0003, 16'h0000, 1, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            if (AR)
                step("per3", 0, 0, 0, 0, 1, 16'h0000, to_bcd(k % 4), 1, (k % 4) == 0, 0);
            else
                step("per3", 0, 0, 0, 0, 1, 16'h0000, to_bcd(k <= 3 ? k : 3), k <= 3, k == 4, 0);
        end

        // Bounded drain of the scoreboard
        repeat (4) @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
